// File: rtl/funcPckg.sv
// Shared elaboration-time helpers.
package funcPckg;

    // Number of bits needed to hold the value n (at least 1).
    function automatic int log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((n >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/im2ColPckg.sv
// im2col beat formats, gather output format and lane helpers.
package im2ColPckg;

    import funcPckg::*;
    import ramPckg::*;

    localparam int cMaxKerWidth = 4;
    localparam int cDataWidth   = 8;
    localparam int cBankW       = log2(cNumOfRam - 1);
    localparam int cRowW        = log2(cRamDepth - 1);

    typedef struct packed {
        logic [cMaxKerWidth-1:0][cBankW-1:0] xAddr;
        logic [cRowW-1:0]                    yAddr;
        logic [cMaxKerWidth-1:0]             dv;
        logic                                done;
    } tIm2ColOut;

    typedef struct packed {
        logic [cMaxKerWidth-1:0][cDataWidth-1:0] data;
        logic [cMaxKerWidth-1:0]                 mask;
        logic                                    last;
    } tGatherOut;

    typedef enum logic [1:0] {idle, run, drain} tIm2ColGatherState;

    // The generator fills dv from the MSB down; bit i of the result is lane i.
    function automatic logic [cMaxKerWidth-1:0] laneValid(input logic [cMaxKerWidth-1:0] dv);
        logic [cMaxKerWidth-1:0] m;
        for (int i = 0; i < cMaxKerWidth; i++) begin
            m[i] = dv[cMaxKerWidth-1-i];
        end
        return m;
    endfunction

endpackage

// File: rtl/ramPckg.sv
// Tile RAM geometry shared by the im2col address generator and its read side.
package ramPckg;

    localparam int cNumOfRam = 8;
    localparam int cRamDepth = 16;

endpackage

// File: rtl/gather_fifo.sv
// Synchronous FIFO of gathered kernel rows; write-to-read latency 1 cycle.
// No full protection: the upstream credit scheme guarantees room for every push.
module gather_fifo
    import im2ColPckg::*;
#(
    parameter int cDepth = 4,
    parameter int cCntW  = $clog2(cDepth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld_i,
    input  tGatherOut        wr_dat_i,
    output logic             rd_vld_o,
    output tGatherOut        rd_dat_o,
    input  logic             rd_rdy_i,
    output logic [cCntW-1:0] count_o
);

    localparam int cPtrW = (cDepth > 1) ? $clog2(cDepth) : 1;

    tGatherOut        mem_q [cDepth];
    logic [cPtrW-1:0] wr_ptr_q;
    logic [cPtrW-1:0] rd_ptr_q;
    logic [cCntW-1:0] count_q;
    logic             pop;

    assign pop      = rd_rdy_i && (count_q != '0);
    assign rd_vld_o = (count_q != '0);
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o  = count_q;

    always_ff @(posedge clk) begin
        if (wr_vld_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_vld_i) begin
                wr_ptr_q <= (wr_ptr_q == cPtrW'(cDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == cPtrW'(cDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + cCntW'(wr_vld_i) - cCntW'(pop);
        end
    end

endmodule

// File: rtl/im2col_row_gather.sv
// Turns im2col bank-address beats into per-lane tile RAM reads and packed kernel rows.
// Accept-to-output latency 3 cycles; addrReady is a registered credit of cFifoDepth beats.
module im2col_row_gather
    import ramPckg::*;
    import im2ColPckg::*;
#(
    parameter int cFifoDepth = 4,
    parameter int cRdLatency = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  tIm2ColOut                            addrIn,
    output logic                                 addrReady,
    output logic [cNumOfRam-1:0]                 ramRdEn,
    output logic [cNumOfRam-1:0][cRowW-1:0]      ramRdAddr,
    input  logic [cNumOfRam-1:0][cDataWidth-1:0] ramRdData,
    output tGatherOut                            dataOut,
    output logic                                 dataOutValid,
    input  logic                                 dataOutReady,
    output logic                                 busy,
    output logic                                 addrErr
);

    localparam int cCntW  = $clog2(cFifoDepth + 1);
    localparam int cUsedW = cCntW + 1;

    if (cRdLatency != 1) begin : g_bad_latency
        $error("im2col_row_gather supports only cRdLatency == 1");
    end

    tIm2ColGatherState state_q, state_d;
    logic addr_rdy_q, addr_rdy_d;
    logic err_q, err_d;
    logic [cNumOfRam-1:0] rd_en_q, rd_en_d;
    logic [cNumOfRam-1:0][cRowW-1:0] rd_addr_q, rd_addr_d;

    logic s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [cMaxKerWidth-1:0][cBankW-1:0] s1_x_q, s1_x_d;
    logic [cMaxKerWidth-1:0] s1_mask_q, s1_mask_d;
    logic s2_vld_q, s2_last_q;
    logic [cMaxKerWidth-1:0][cBankW-1:0] s2_x_q;
    logic [cMaxKerWidth-1:0] s2_mask_q;

    logic accept, pop;
    logic [cMaxKerWidth-1:0] lanes;
    logic [cCntW-1:0] fifo_cnt;
    logic [cUsedW-1:0] used_d;
    tGatherOut push_dat;

    assign pop          = dataOutValid && dataOutReady;
    assign addrReady    = addr_rdy_q;
    assign ramRdEn      = rd_en_q;
    assign ramRdAddr    = rd_addr_q;
    assign busy         = (state_q != idle);
    assign addrErr      = err_q;

    // Accept stage: decode lanes into bank reads; out-of-range banks are dropped and flagged.
    always_comb begin
        accept    = addr_rdy_q && ((addrIn.dv != '0) || addrIn.done);
        lanes     = laneValid(addrIn.dv);
        rd_en_d   = '0;
        rd_addr_d = rd_addr_q;
        err_d     = err_q;
        s1_mask_d = '0;
        s1_vld_d  = accept;
        s1_x_d    = addrIn.xAddr;
        s1_last_d = addrIn.done;
        if (accept) begin
            for (int i = 0; i < cMaxKerWidth; i++) begin
                if (lanes[i]) begin
                    if (int'(addrIn.xAddr[i]) < cNumOfRam) begin
                        s1_mask_d[i]                = 1'b1;
                        rd_en_d[addrIn.xAddr[i]]    = 1'b1;
                        rd_addr_d[addrIn.xAddr[i]]  = addrIn.yAddr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        push_dat      = '0;
        push_dat.mask = s2_mask_q;
        push_dat.last = s2_last_q;
        for (int i = 0; i < cMaxKerWidth; i++) begin
            if (s2_mask_q[i]) begin
                push_dat.data[i] = ramRdData[s2_x_q[i]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            idle:    if (accept) state_d = addrIn.done ? drain : run;
            run:     if (accept && addrIn.done) state_d = drain;
            drain:   if (pop && dataOut.last) state_d = idle;
            default: state_d = idle;
        endcase
    end

    // Credit looks at next-cycle occupancy, so a pop only frees room one cycle later.
    always_comb begin
        used_d = cUsedW'(fifo_cnt) + cUsedW'(s2_vld_q) - cUsedW'(pop)
               + cUsedW'(s1_vld_d) + cUsedW'(s1_vld_q);
        addr_rdy_d = (state_d != drain) && (used_d < cUsedW'(cFifoDepth));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= idle;
            addr_rdy_q <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= '0;
            rd_addr_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_mask_q  <= '0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_x_q     <= '0;
            s2_mask_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_rdy_q <= addr_rdy_d;
            err_q      <= err_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            s1_vld_q   <= s1_vld_d;
            s1_x_q     <= s1_x_d;
            s1_mask_q  <= s1_mask_d;
            s1_last_q  <= s1_last_d;
            s2_vld_q   <= s1_vld_q;
            s2_x_q     <= s1_x_q;
            s2_mask_q  <= s1_mask_q;
            s2_last_q  <= s1_last_q;
        end
    end

    gather_fifo #(
        .cDepth (cFifoDepth),
        .cCntW  (cCntW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_vld_i (s2_vld_q),
        .wr_dat_i (push_dat),
        .rd_vld_o (dataOutValid),
        .rd_dat_o (dataOut),
        .rd_rdy_i (dataOutReady),
        .count_o  (fifo_cnt)
    );

endmodule

// File: doc/im2col_row_gather.md
# im2col_row_gather

Read side of the im2col address stream. Consumes the per-cycle bank-address beats (`tIm2ColOut`) produced by the im2col address generator and issues the corresponding reads to the `cNumOfRam` tile RAM banks. It aligns each bank's read data to its kernel lane, zero-fills unused lanes and pushes one packed int8 kernel-row vector per beat toward the MAC array. A valid/ready output with internal buffering backpressures the address generator.

## Interface
Parameters:
- `cDataWidth`, 8: bits per RAM word / lane (int8).
- `cFifoDepth`, 4: output buffer depth; also the credit limit for in-flight beats.
- `cRdLatency`, 1: tile RAM read latency in cycles. Fixed at 1 for this version.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `addrIn`  in  `tIm2ColOut`  address beat: `xAddr[cMaxKerWidth]`, `yAddr`, `dv[cMaxKerWidth]`, `done`.
- `addrReady`  out  1  beat accepted on a rising edge when `addrReady` is high and `addrIn.dv != 0` or `addrIn.done` is set.
- `ramRdEn`  out  `cNumOfRam`  per-bank read enable.
- `ramRdAddr`  out  `cNumOfRam` x `log2(cRamDepth-1)`  per-bank row address.
- `ramRdData`  in  `cNumOfRam` x `cDataWidth`  per-bank read data, valid `cRdLatency` cycles after `ramRdEn`.
- `dataOut`  out  `tGatherOut`  fields: `data[cMaxKerWidth][cDataWidth]`, `mask[cMaxKerWidth]`, `last`.
- `dataOutValid`  out  1  `dataOut` holds a beat.
- `dataOutReady`  in  1  consumer pops the beat on an edge where valid and ready are both high.
- `busy`  out  1  state is not IDLE.
- `addrErr`  out  1  sticky flag for an out-of-range bank index.

## Operation
- Lane mapping: lane `i` is valid when `dv[cMaxKerWidth-1-i]` is set. This matches the generator encoding, where width 1 gives `4'b1000` = lane 0. Lane `i` reads bank `xAddr[i]` at row `yAddr`. Output `mask[i]` is normalized so that bit `i` = lane `i`.
- Bank indices wrap modulo `2^log2(cNumOfRam-1)`, which is the generator's natural wrap.
- Out-of-range lanes: a valid lane with `xAddr[i] >= cNumOfRam` gets no read, data 0 and mask bit 0, and sets `addrErr`. `addrErr` holds until reset.
- Design constraint: `cMaxKerWidth <= cNumOfRam`. Under this constraint, valid lanes of one beat never share a bank.
- Invalid lanes: `data[i] = 0`, `mask[i] = 0`.
- `done`: the beat that carries `done` produces an output beat with `last=1`. If `dv=0` on that beat, the output is an all-zero beat with `mask=0` and `last=1`.
- FSM:
  - IDLE -> RUN on the first accepted beat without `done`.
  - IDLE/RUN -> DRAIN on an accepted beat with `done`.
  - DRAIN -> IDLE on the edge that pops the `last` beat.
  - `addrReady=0` in DRAIN.
- Credit rule: `addrReady = (state != DRAIN) && (inFlight + fifoCount < cFifoDepth)`. `inFlight` counts beats in stages S1 and S2. A pop frees its credit on the following cycle, not combinationally.
- Reset: asynchronous; all outputs go to 0 immediately. This covers `addrReady`, `ramRdEn`, `ramRdAddr`, `dataOut`, `dataOutValid`, `busy` and `addrErr`. The FIFO and pipeline empty, and the state returns to IDLE.
  - `addrReady` returns to 1 on the first edge after `rst` deasserts.
  - A beat in flight at reset is discarded, with no partial output.

## Timing
- Accept edge at end of cycle T:
  - S1, cycle T+1: registered `ramRdEn`/`ramRdAddr` are driven.
  - S2, cycle T+2: `ramRdData` is valid; the lane mux and zero-fill run and the result is written to the FIFO at the end of T+2.
  - Cycle T+3: `dataOutValid` is high if the FIFO was empty.
- Minimum latency is 3 cycles, accept to output. Throughput is 1 beat/cycle with `dataOutReady` held high.
- `ramRdEn`/`ramRdAddr` are registered only, with no combinational path from `addrIn`. `ramRdAddr` holds its last value when not enabled.
- Simultaneous FIFO push and pop: count is unchanged and order is preserved. FIFO full cannot occur, because the credits guarantee room.
- `dataOut` is stable while `dataOutValid && !dataOutReady`.

## Structure
- `im2ColPckg` gains:
  - `tGatherOut`
  - `tIm2ColGatherState` enum {idle, run, drain}
  - `cDataWidth`
  - a function `laneValid(dv)` returning the normalized mask
- `cNumOfRam` and `cRamDepth` come from `ramPckg`; `log2` comes from `funcPckg`.
- One sub-module: `gather_fifo`, a synchronous FIFO of `tGatherOut` with depth `cFifoDepth`, count output and async active-high reset. The pipeline, lane crossbar and FSM stay in the top module.

## Test plan
Bank `b` row `y` is preloaded with `{b[3:0], y[3:0]}`; `cNumOfRam=8`.
- Width 4, startX=2, Y=5, dv=1111 -> `ramRdEn=8'b0011_1100` at T+1, all addresses 5; at T+3 data={0x25,0x35,0x45,0x55}, mask=1111.
- Width 1, startX=7, Y=3, dv=1000 -> only `ramRdEn[7]`; data={0x73,0,0,0}, mask=0001.
- Wrap: width 4, startX=6, Y=1 -> banks 6,7,0,1; data={0x61,0x71,0x01,0x11}.
- Backpressure: `dataOutReady=0`, source offers 8 beats -> `addrReady` drops after 4 accepted. Release ready -> all 8 beats emerge in order with no loss or duplication.
- `done` beat (width 2) -> `last=1`, mask=0011, `addrReady=0` during DRAIN; `busy` falls on the edge that pops `last`.
- Assert `rst` asynchronously mid-stream with 3 beats buffered -> all outputs 0 before the next edge, and no stale beat appears after release.
